note_seq_display: RTL and testbench



---
 rtl/note_seq_display.sv | 263 ++++++++++++++++++++++++++
 tb/tb_note_seq_display.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_seq_display.sv
// -----------------------------------------------------------------------------
// note_seq_display
//
// Purpose:
//   Accepts a stream of notes {tom, note} over a valid/ready handshake and
//   buffers them in a FIFO. Each note is played for HOLD_CYCLES clocks before
//   the next one is popped. The last DIGITS played notes form a scrolling
//   history that is shown on a time-multiplexed multi-digit 7-segment display.
//
// Parameters:
//   DIGITS      - number of multiplexed digits / history depth (1..8)
//   FIFO_DEPTH  - input buffer entries (power of 2, >= 2)
//   HOLD_CYCLES - clocks each note is held before the next pop (>= 2)
//   SCAN_CYCLES - clocks each digit stays enabled per scan step (>= 1)
//
// Ports:
//   Clock        - system clock, rising edge
//   Reset        - synchronous, active-high
//   in_valid     - a note is offered
//   in_ready     - FIFO not full (combinational from the registered count)
//   in_tom       - tone flag, 1 = sharp
//   in_note      - 0..6 = C D E F G A B, 7 = rest
//   seg          - segments a..g on seg[6]..seg[0], active-high, registered
//   digit_sel    - one-hot digit enable, active-high, registered
//   playing      - high while the sequencer is in PLAY
//   note_strobe  - one-cycle pulse, registered, following each FIFO pop
//   fifo_count   - current FIFO occupancy
//   seg_dp       - (NOTE_SHARP_DP_EN only) decimal point = sharp flag of the
//                  displayed slot; rest and blank slots force it low
//
// Optional feature macro: NOTE_SHARP_DP_EN
// -----------------------------------------------------------------------------
module note_seq_display #(
  parameter int DIGITS      = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 1000,
  parameter int SCAN_CYCLES = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_tom,
  input  logic [2:0]                    in_note,
  output logic [6:0]                    seg,
  output logic [DIGITS-1:0]             digit_sel,
  output logic                          playing,
  output logic                          note_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef NOTE_SHARP_DP_EN
  ,
  output logic                          seg_dp
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int HW  = $clog2(HOLD_CYCLES);
  localparam int SIW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SDW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SIW-1:0] IDX_LAST   = SIW'(DIGITS - 1);
  localparam logic [SDW-1:0] DIV_LAST   = SDW'(SCAN_CYCLES - 1);

  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_G     = 7'b1011110;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_REST  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  // FIFO storage and control
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  // Sequencer
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  // History: bit 4 marks a slot that has been loaded, bits 3:0 = {tom, note}
  logic [4:0]    hist_q [DIGITS];
  logic [4:0]    hist_d [DIGITS];

  // Display scan and output registers
  logic [SDW-1:0]    div_q, div_d;
  logic [SIW-1:0]    idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              strobe_q, strobe_d;
  logic [4:0]        disp_entry;

  function automatic logic [6:0] decode_seg(input logic [4:0] entry);
    logic [6:0] code;
    code = SEG_BLANK;
    if (entry[4]) begin
      case (entry[2:0])
        3'd0:    code = SEG_C;
        3'd1:    code = SEG_D;
        3'd2:    code = SEG_E;
        3'd3:    code = SEG_F;
        3'd4:    code = SEG_G;
        3'd5:    code = SEG_A;
        3'd6:    code = SEG_B;
        default: code = SEG_REST;
      endcase
    end
    return code;
  endfunction

  // in_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // Sequencer next state; pop is derived here because it depends on the hold
  // timer as well as on FIFO occupancy.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_PLAY;
          hold_d  = HOLD_LAST;
        end
      end
      S_PLAY: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (!empty) begin
          pop    = 1'b1;
          hold_d = HOLD_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // On a pop the history shifts one place; the oldest slot falls off the end.
  always_comb begin
    hist_d = hist_q;
    if (pop) begin
      hist_d[0] = {1'b1, mem_q[rd_ptr_q]};
      for (int k = 1; k < DIGITS; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  // Scan divider and digit index, plus the registered display outputs which
  // lag the scan index by one clock.
  assign disp_entry = hist_q[idx_q];

  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SIW'(1);
    end else begin
      div_d = div_q + SDW'(1);
    end
    for (int i = 0; i < DIGITS; i++) begin
      sel_d[i] = (idx_q == SIW'(i));
    end
    seg_d    = decode_seg(disp_entry);
    strobe_d = pop;
  end

  // FIFO data array is not reset; entries are only read after being written.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_tom, in_note};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      hold_q   <= '0;
      for (int k = 0; k < DIGITS; k++) hist_q[k] <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      sel_q    <= DIGITS'(1);
      strobe_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      hist_q   <= hist_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
    end
  end

  assign seg         = seg_q;
  assign digit_sel   = sel_q;
  assign playing     = (state_q == S_PLAY);
  assign note_strobe = strobe_q;
  assign fifo_count  = count_q;

`ifdef NOTE_SHARP_DP_EN
  logic dp_q, dp_d;

  // Sharp flag only lights on a loaded, non-rest slot.
  always_comb begin
    dp_d = disp_entry[4] && (disp_entry[2:0] != 3'd7) && disp_entry[3];
  end

  always_ff @(posedge Clock) begin
    if (Reset) dp_q <= 1'b0;
    else       dp_q <= dp_d;
  end

  assign seg_dp = dp_q;
`else
  // The sharp flag is still carried through the FIFO and history but drives
  // nothing in this build.
  logic tom_unused;
  assign tom_unused = disp_entry[3];
`endif

endmodule

// File: tb/tb_note_seq_display.sv
// -----------------------------------------------------------------------------
// tb_note_seq_display
//
// Directed scenarios followed by a randomized phase. A queue-based reference
// model tracks the FIFO contents, the played-note history, and the time of
// the last pop; display outputs are derived from the number of clocks since
// reset. Define NOTE_SHARP_DP_EN for both files to exercise seg_dp.
// -----------------------------------------------------------------------------
module tb_note_seq_display;

  localparam int DIGITS      = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int SCAN_CYCLES = 2;

  logic                        Clock = 1'b0;
  logic                        Reset;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_tom;
  logic [2:0]                  in_note;
  logic [6:0]                  seg;
  logic [DIGITS-1:0]           digit_sel;
  logic                        playing;
  logic                        note_strobe;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef NOTE_SHARP_DP_EN
  logic                        seg_dp;
`endif

  note_seq_display #(
    .DIGITS      (DIGITS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .SCAN_CYCLES (SCAN_CYCLES)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tom      (in_tom),
    .in_note     (in_note),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .playing     (playing),
    .note_strobe (note_strobe),
    .fifo_count  (fifo_count)
`ifdef NOTE_SHARP_DP_EN
    ,
    .seg_dp      (seg_dp)
`endif
  );

  always #5 Clock = ~Clock;

  int total;
  int bad;

  // Reference model state
  logic [3:0]        fifo_m[$];
  logic [3:0]        hist_m[$];
  bit                play_m;
  int                last_pop_m;
  int                edges_m;
  bit                strobe_m;
  bit                accepted_m;
  logic [6:0]        seg_m;
  logic [DIGITS-1:0] sel_m;
  bit                dp_m;

  function automatic logic [6:0] noteSeg(input logic [2:0] n);
    case (n)
      3'd0:    return 7'b1001110;
      3'd1:    return 7'b0111101;
      3'd2:    return 7'b1001111;
      3'd3:    return 7'b1000111;
      3'd4:    return 7'b1011110;
      3'd5:    return 7'b1110111;
      3'd6:    return 7'b0011111;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic compareValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelStep();
    int         e;
    int         idx;
    bit         push;
    bit         pop;
    logic [3:0] entry;
    if (Reset) begin
      fifo_m.delete();
      hist_m.delete();
      play_m     = 1'b0;
      strobe_m   = 1'b0;
      edges_m    = 0;
      last_pop_m = 0;
      sel_m      = DIGITS'(1);
      seg_m      = 7'b0;
      dp_m       = 1'b0;
      accepted_m = 1'b0;
      return;
    end
    e   = edges_m + 1;
    idx = (edges_m / SCAN_CYCLES) % DIGITS;
    sel_m      = '0;
    sel_m[idx] = 1'b1;
    if (idx < hist_m.size()) begin
      entry = hist_m[idx];
      seg_m = noteSeg(entry[2:0]);
      dp_m  = entry[3] && (entry[2:0] != 3'd7);
    end else begin
      seg_m = 7'b0;
      dp_m  = 1'b0;
    end
    push = in_valid && (fifo_m.size() < FIFO_DEPTH);
    pop  = (fifo_m.size() > 0) && (!play_m || (e - last_pop_m == HOLD_CYCLES));
    if (pop) begin
      entry = fifo_m.pop_front();
      hist_m.push_front(entry);
      if (hist_m.size() > DIGITS) void'(hist_m.pop_back());
      play_m     = 1'b1;
      last_pop_m = e;
    end else if (play_m && (e - last_pop_m == HOLD_CYCLES)) begin
      play_m = 1'b0;
    end
    strobe_m = pop;
    if (push) fifo_m.push_back({in_tom, in_note});
    accepted_m = push;
    edges_m    = e;
  endtask

  task automatic checkOutput();
    compareValue("in_ready", in_ready, fifo_m.size() < FIFO_DEPTH);
    compareValue("fifo_count", fifo_count, fifo_m.size());
    compareValue("playing", playing, play_m);
    compareValue("note_strobe", note_strobe, strobe_m);
    compareValue("digit_sel", digit_sel, sel_m);
    compareValue("seg", seg, seg_m);
`ifdef NOTE_SHARP_DP_EN
    compareValue("seg_dp", seg_dp, dp_m);
`endif
  endtask

  task automatic tick();
    modelStep();
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input bit tom,
                               input logic [2:0] note);
    Reset    = rst;
    in_valid = v;
    in_tom   = tom;
    in_note  = note;
    tick();
  endtask

  // Hold in_valid until the note is taken, bounded.
  task automatic pushNote(input bit tom, input logic [2:0] note);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      applyStimulus(1'b0, 1'b1, tom, note);
      done = accepted_m;
    end
    in_valid = 1'b0;
    if (!done) compareValue("push_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (play_m || fifo_m.size() != 0); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    end
    if (play_m || fifo_m.size() != 0) compareValue("drain_timeout", 0, 1);
  endtask

  // Walk a full scan and compare each digit (selected by mask) to constants.
  task automatic scanDigits(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3,
                            input logic [3:0] mask);
    logic [6:0] exp_d[4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int t = 0; t < 2 * SCAN_CYCLES * DIGITS; t++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
      for (int d = 0; d < DIGITS; d++) begin
        if (sel_m[d] && mask[d]) compareValue($sformatf("scan_digit%0d", d), seg, exp_d[d]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    play_m = 1'b0; strobe_m = 1'b0; edges_m = 0; last_pop_m = 0;
    sel_m = DIGITS'(1); seg_m = '0; dp_m = 1'b0; accepted_m = 1'b0;

    // Reset for two cycles, then check reset values against constants
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    compareValue("rst_seg", seg, 7'b0000000);
    compareValue("rst_digit_sel", digit_sel, 4'b0001);
    compareValue("rst_in_ready", in_ready, 1);
    compareValue("rst_playing", playing, 0);
    compareValue("rst_fifo_count", fifo_count, 0);
    compareValue("rst_strobe", note_strobe, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);

    // Single note C from idle: pop one cycle after push, strobe the next
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    in_valid = 1'b0;
    compareValue("single_count_after_push", fifo_count, 1);
    compareValue("single_strobe_early", note_strobe, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    compareValue("single_count_after_pop", fifo_count, 0);
    compareValue("single_strobe", note_strobe, 1);
    compareValue("single_playing", playing, 1);
    for (int i = 1; i <= HOLD_CYCLES; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
      compareValue("single_hold_playing", playing, (i < HOLD_CYCLES) ? 1 : 0);
      compareValue("single_hold_strobe", note_strobe, 0);
    end
    scanDigits(7'b1001110, 7'b0, 7'b0, 7'b0, 4'b1111);

    // Five notes back to back: C D E F G
    for (int n = 0; n < 5; n++) pushNote(1'b0, 3'(n));
    drain();
    scanDigits(7'b1011110, 7'b1000111, 7'b1001111, 7'b0111101, 4'b1111);

    // Fill the FIFO with in_valid held across the pop cycle
    for (int n = 0; n < 6; n++) pushNote(1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)));
    drain();

    // Rest note
    pushNote(1'b0, 3'd7);
    drain();
    scanDigits(7'b0000001, 7'b0, 7'b0, 7'b0, 4'b0001);

`ifdef NOTE_SHARP_DP_EN
    pushNote(1'b1, 3'd5);
    drain();
    scanDigits(7'b1110111, 7'b0, 7'b0, 7'b0, 4'b0001);
    for (int t = 0; t < 2 * SCAN_CYCLES * DIGITS; t++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
      if (sel_m[0]) compareValue("sharp_dp", seg_dp, 1);
    end
`endif

    // Reset during PLAY with three notes queued
    for (int n = 0; n < 4; n++) pushNote(1'b0, 3'(n + 1));
    compareValue("pre_reset_count", fifo_count, 3);
    compareValue("pre_reset_playing", playing, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    compareValue("mid_reset_count", fifo_count, 0);
    compareValue("mid_reset_playing", playing, 0);
    compareValue("mid_reset_seg", seg, 7'b0);
    compareValue("mid_reset_sel", digit_sel, 4'b0001);
    for (int t = 0; t < 2 * SCAN_CYCLES * DIGITS + 4; t++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
      compareValue("post_reset_strobe", note_strobe, 0);
      compareValue("post_reset_seg", seg, 7'b0);
    end

    // Randomized traffic with occasional resets
    for (int t = 0; t < 600; t++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)));
    end
    in_valid = 1'b0;
    Reset    = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
